// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch feeding a 2-entry {inst,pc}
//            queue. Optional macro FETCH_BYPASS_EN presents an accepted memory
//            response combinationally when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                  ADDRSIZE = 64,
    parameter logic [ADDRSIZE-1:0] RESETPC  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [ADDRSIZE-1:0] target,
    output logic                imem_req,
    output logic [ADDRSIZE-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_data,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [ADDRSIZE-1:0] inst_pc,
    input  logic                inst_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]          state;
    logic [ADDRSIZE-1:0] pc;
    logic [ADDRSIZE-1:0] req_addr;

    logic [31:0]         q_inst [0:1];
    logic [ADDRSIZE-1:0] q_pc   [0:1];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;

    logic                issue;
    logic                accept;
    logic                bypass;
    logic                push;
    logic                pop;

    // rst gates the idle request so imem_req reads 0 while reset is held
    assign issue  = (state == IDLE) && (count < 2'd2) && !redirect && !rst;
    assign accept = (state == WAIT) && imem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = accept && (count == 2'd0);
`else
    assign bypass = 1'b0;
`endif

    assign imem_req   = issue || (state == WAIT) || (state == DRAIN);
    assign imem_addr  = (state == IDLE) ? pc : req_addr;

    assign inst_valid = !redirect && ((count != 2'd0) || bypass);
    assign inst       = bypass ? imem_data : q_inst[rd_ptr];
    assign inst_pc    = bypass ? req_addr  : q_pc[rd_ptr];

    // A bypassed word consumed in its ack cycle never occupies a queue slot
    assign pop  = inst_valid && inst_ready && (count != 2'd0);
    assign push = accept && !(bypass && inst_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESETPC;
            req_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= WAIT;
                        req_addr <= pc;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state <= IDLE;
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (redirect) begin
                pc <= target;
            end else if (accept) begin
                pc <= req_addr + ADDRSIZE'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_inst[0] <= '0;
            q_inst[1] <= '0;
            q_pc[0]   <= '0;
            q_pc[1]   <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
        end else if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_inst[wr_ptr] <= imem_data;
                q_pc[wr_ptr]   <= req_addr;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire
